// File: rtl/dbg_dispatch_pkg.sv
// dbg_dispatch_pkg: shared command type, field positions and channel-width helper
//   CMD_DATA_W / CMD_IR_W : default shift-register and virtual-IR widths
//   ACT_BIT / CH_MSB      : action flag and channel-field MSB positions in sr
//   cmd_t                 : queued command {ir, sr}
//   ch_w()                : channel-field width, max(1, clog2(num_ch))
package dbg_dispatch_pkg;
    localparam int CMD_DATA_W = 38;
    localparam int CMD_IR_W   = 2;
    localparam int ACT_BIT    = CMD_DATA_W - 1;
    localparam int CH_MSB     = CMD_DATA_W - 2;
    typedef struct packed {
        logic [CMD_IR_W-1:0]   ir;
        logic [CMD_DATA_W-1:0] sr;
    } cmd_t;
    function automatic int ch_w(input int num_ch);
        return num_ch <= 2 ? 1 : $clog2(num_ch);
    endfunction
endpackage

// File: rtl/dbg_cmd_dispatch_if.sv
// dbg_cmd_dispatch_if: per-core command offer bus with valid/ready handshake
//   cmd_valid  one-hot offer to core i
//   ch_ready   per-core accept
//   cmd_ir     IR of offered command
//   cmd_action 1 = take_action, 0 = take_no_action
//   jdo        sr snapshot of offered command
//   master: dispatcher side, slave: core side
interface dbg_cmd_dispatch_if import dbg_dispatch_pkg::*; #(
    parameter int DATA_W = CMD_DATA_W,
    parameter int IR_W   = CMD_IR_W,
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] cmd_valid;
    logic [NUM_CH-1:0] ch_ready;
    logic [IR_W-1:0]   cmd_ir;
    logic              cmd_action;
    logic [DATA_W-1:0] jdo;
    modport master (output cmd_valid, cmd_ir, cmd_action, jdo, input ch_ready);
    modport slave (input cmd_valid, cmd_ir, cmd_action, jdo, output ch_ready);
endinterface

// File: rtl/dbg_sync_edge.sv
// dbg_sync_edge: strobe synchroniser with rising-edge detect, masked until armed after reset
//   clk, reset : system clock, asynchronous active-high reset
//   d          : asynchronous strobe
//   rise       : one-cycle pulse on synchronised rising edge
module dbg_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);
    localparam int AW = $clog2(STAGES + 2);
    logic [STAGES-1:0] sync;
    logic              prev;
    logic [AW-1:0]     arm;
    logic              armed;
    // Arming after STAGES+1 clocks lets a strobe held high through reset
    // fill both the chain and prev, so it never looks like an edge.
    assign armed = arm == AW'(STAGES + 1);
    assign rise  = armed && sync[STAGES-1] && !prev;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
            arm  <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
            if (!armed) arm <= arm + 1'b1;
        end
    end
endmodule

// File: rtl/dbg_cmd_dispatch.sv
// dbg_cmd_dispatch: system-clock JTAG debug command queue and per-core dispatcher
//   clk, reset        : system clock, asynchronous active-high reset
//   vs_uir, vs_udr    : TCK-domain update-IR / update-DR strobes (async)
//   ir_in, sr         : virtual IR and shift register
//   clear_err         : clears sticky error flags
//   cmd (master)      : cmd_valid/ch_ready/cmd_ir/cmd_action/jdo offer bus
//   ir_q, ir_update   : IR latched at last uir edge, one-cycle pulse after it
//   busy              : queue non-empty
//   err_ovf, err_badch: sticky drop flags (queue full, channel out of range)
//   stat_cnt          : per-channel saturating handshake counts when
//                       DBG_DISPATCH_STATS_EN is defined, otherwise 0
module dbg_cmd_dispatch import dbg_dispatch_pkg::*; #(
    parameter int DATA_W      = CMD_DATA_W,
    parameter int IR_W        = CMD_IR_W,
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vs_uir,
    input  logic                 vs_udr,
    input  logic [IR_W-1:0]      ir_in,
    input  logic [DATA_W-1:0]    sr,
    input  logic                 clear_err,
    dbg_cmd_dispatch_if.master   cmd,
    output logic [IR_W-1:0]      ir_q,
    output logic                 ir_update,
    output logic                 busy,
    output logic                 err_ovf,
    output logic                 err_badch,
    output logic [16*NUM_CH-1:0] stat_cnt
);
    localparam int CH_W = ch_w(NUM_CH);
    localparam int AW   = $clog2(FIFO_DEPTH);
    cmd_t            mem [FIFO_DEPTH];
    cmd_t            entry;
    cmd_t            head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            uir_rise;
    logic            udr_rise;
    logic [CH_W-1:0] in_ch;
    logic [CH_W-1:0] head_ch;
    logic            bad_ch;
    logic            full;
    logic            pop;
    logic            push;
    logic            ovf;

    dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_uir (.clk(clk), .reset(reset), .d(vs_uir), .rise(uir_rise));
    dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_udr (.clk(clk), .reset(reset), .d(vs_udr), .rise(udr_rise));

    // A uir edge in the same cycle as the udr edge supplies the fresh IR.
    assign entry   = '{ir: uir_rise ? ir_in : ir_q, sr: sr};
    assign in_ch   = entry.sr[CH_MSB -: CH_W];
    assign bad_ch  = 32'(in_ch) >= NUM_CH;
    assign head    = mem[rd_ptr];
    assign head_ch = head.sr[CH_MSB -: CH_W];
    assign busy    = count != '0;
    assign full    = count == (AW+1)'(FIFO_DEPTH);
    assign pop     = busy && cmd.ch_ready[head_ch];
    assign push    = udr_rise && !bad_ch && (!full || pop);
    assign ovf     = udr_rise && !bad_ch && full && !pop;

    // Offer outputs gated by busy so everything reads 0 when empty or in reset.
    assign cmd.cmd_valid  = busy ? NUM_CH'(1) << head_ch : '0;
    assign cmd.cmd_ir     = busy ? head.ir : '0;
    assign cmd.cmd_action = busy && head.sr[ACT_BIT];
    assign cmd.jdo        = busy ? head.sr : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ir_q      <= '0;
            ir_update <= 1'b0;
            err_ovf   <= 1'b0;
            err_badch <= 1'b0;
        end else begin
            if (uir_rise) ir_q <= ir_in;
            ir_update <= uir_rise;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count     <= count + (AW+1)'(push) - (AW+1)'(pop);
            err_ovf   <= ovf || (err_ovf && !clear_err);
            err_badch <= (udr_rise && bad_ch) || (err_badch && !clear_err);
        end
    end

`ifdef DBG_DISPATCH_STATS_EN
    for (genvar i = 0; i < NUM_CH; i++) begin : g_stat
        logic [15:0] cnt;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) cnt <= '0;
            else if (pop && head_ch == CH_W'(i) && cnt != 16'hFFFF) cnt <= cnt + 1'b1;
        end
        assign stat_cnt[16*i +: 16] = cnt;
    end
`else
    assign stat_cnt = '0;
`endif
endmodule

// File: tb/tb_dbg_cmd_dispatch.sv
// tb_dbg_cmd_dispatch: directed bench for dbg_cmd_dispatch (4-channel main DUT, 3-channel DUT for bad-channel drops)
module tb_dbg_cmd_dispatch;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vs_uir = 1'b0;
    logic        vs_udr = 1'b0;
    logic [1:0]  ir_in = '0;
    logic [37:0] sr = '0;
    logic        clear_err = 1'b0;
    logic [1:0]  ir_q, ir_q3;
    logic        ir_update, ir_update3;
    logic        busy, busy3;
    logic        err_ovf, err_ovf3;
    logic        err_badch, err_badch3;
    logic [63:0] stat_cnt;
    logic [47:0] stat_cnt3;
    int          tests = 0;
    int          fails = 0;

    dbg_cmd_dispatch_if #(.NUM_CH(4)) if4 ();
    dbg_cmd_dispatch_if #(.NUM_CH(3)) if3 ();
    assign if3.ch_ready = 3'b111;

    always #5 clk = ~clk;

    dbg_cmd_dispatch #(.NUM_CH(4)) dut (
        .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in), .sr(sr),
        .clear_err(clear_err), .cmd(if4), .ir_q(ir_q), .ir_update(ir_update), .busy(busy),
        .err_ovf(err_ovf), .err_badch(err_badch), .stat_cnt(stat_cnt)
    );

    dbg_cmd_dispatch #(.NUM_CH(3)) dut3 (
        .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in), .sr(sr),
        .clear_err(clear_err), .cmd(if3), .ir_q(ir_q3), .ir_update(ir_update3), .busy(busy3),
        .err_ovf(err_ovf3), .err_badch(err_badch3), .stat_cnt(stat_cnt3)
    );

    function automatic logic [37:0] mk_sr(input logic act, input logic [1:0] ch, input logic [34:0] pl);
        return {act, ch, pl};
    endfunction

    // All stimulus tasks start and end on a falling edge; a strobe leaves the
    // bench three falling edges later, when the pushed command is visible.
    task automatic udr(input logic [37:0] s);
        sr = s;
        vs_udr = 1'b1;
        @(negedge clk);
        vs_udr = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic uir(input logic [1:0] ir);
        ir_in = ir;
        vs_uir = 1'b1;
        @(negedge clk);
        vs_uir = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        tests++;
        if ({if4.cmd_valid, if4.cmd_ir, if4.cmd_action, if4.jdo, ir_q, ir_update, busy, err_ovf, err_badch, stat_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%b busy=%b ovf=%b badch=%b jdo=%h expected all 0", if4.cmd_valid, busy, err_ovf, err_badch, if4.jdo);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        logic [37:0] s;
        s = mk_sr(1'b1, 2'd2, 35'h1_2345_6789);
        if4.ch_ready = 4'b1111;
        uir(2'd1);
        tests++;
        if (ir_q !== 2'd1 || ir_update !== 1'b1) begin fails++; $display("FAIL uir_capture: ir_q=%0d ir_update=%b expected 1 1", ir_q, ir_update); end
        udr(s);
        tests++;
        if (if4.cmd_valid !== 4'b0100) begin fails++; $display("FAIL single_valid: got %b expected 0100", if4.cmd_valid); end
        tests++;
        if (if4.cmd_action !== 1'b1 || if4.cmd_ir !== 2'd1) begin fails++; $display("FAIL single_action_ir: action=%b ir=%0d expected 1 1", if4.cmd_action, if4.cmd_ir); end
        tests++;
        if (if4.jdo !== s) begin fails++; $display("FAIL single_jdo: got %h expected %h", if4.jdo, s); end
        @(negedge clk);
        tests++;
        if (if4.cmd_valid !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL single_pop: valid=%b busy=%b expected 0000 0", if4.cmd_valid, busy); end
        tests++;
        if (ir_update !== 1'b0) begin fails++; $display("FAIL ir_update_pulse: got %b expected 0", ir_update); end
    endtask

    task automatic test_stall();
        logic [37:0] s;
        s = mk_sr(1'b0, 2'd2, 35'h5_5AA5_0F0F);
        if4.ch_ready = 4'b1011;
        udr(s);
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (if4.cmd_valid !== 4'b0100 || if4.jdo !== s || if4.cmd_action !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold[%0d]: valid=%b jdo=%h action=%b expected 0100 %h 0", i, if4.cmd_valid, if4.jdo, if4.cmd_action, s);
            end
            @(negedge clk);
        end
        if4.ch_ready = 4'b1111;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL stall_busy_before: got %b expected 1", busy); end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || if4.cmd_valid !== 4'b0000) begin fails++; $display("FAIL stall_release: busy=%b valid=%b expected 0 0000", busy, if4.cmd_valid); end
    endtask

    task automatic test_overflow();
        logic [37:0] e [5];
        logic [1:0]  ch [5];
        ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int k = 0; k < 5; k++) e[k] = mk_sr(k[0], ch[k], 35'(32'hC0DE_0000 + k));
        if4.ch_ready = 4'b0000;
        for (int k = 0; k < 4; k++) udr(e[k]);
        tests++;
        if (err_ovf !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL ovf_full_no_err: ovf=%b busy=%b expected 0 1", err_ovf, busy); end
        udr(e[4]);
        tests++;
        if (err_ovf !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b expected 1", err_ovf); end
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        tests++;
        if (err_ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b expected 0", err_ovf); end
        if4.ch_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (if4.jdo !== e[k] || if4.cmd_valid !== 4'(1 << ch[k])) begin
                fails++;
                $display("FAIL drain_order[%0d]: jdo=%h valid=%b expected %h %b", k, if4.jdo, if4.cmd_valid, e[k], 4'(1 << ch[k]));
            end
            @(negedge clk);
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL drain_empty: got %b expected 0", busy); end
    endtask

    task automatic test_badch();
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        tests++;
        if (err_badch3 !== 1'b0) begin fails++; $display("FAIL badch_precleared: got %b expected 0", err_badch3); end
        if4.ch_ready = 4'b1111;
        udr(mk_sr(1'b1, 2'd3, 35'h0_0000_0BAD));
        tests++;
        if (err_badch3 !== 1'b1 || busy3 !== 1'b0 || if3.cmd_valid !== 3'b000) begin
            fails++;
            $display("FAIL badch_drop: badch=%b busy=%b valid=%b expected 1 0 000", err_badch3, busy3, if3.cmd_valid);
        end
        tests++;
        if (err_badch !== 1'b0 || if4.cmd_valid !== 4'b1000) begin fails++; $display("FAIL badch_valid_ch3: badch=%b valid=%b expected 0 1000", err_badch, if4.cmd_valid); end
        @(negedge clk);
        tests++;
        if (busy3 !== 1'b0) begin fails++; $display("FAIL badch_busy: got %b expected 0", busy3); end
    endtask

    task automatic test_reset_hold();
        logic [37:0] s;
        if4.ch_ready = 4'b0000;
        udr(mk_sr(1'b1, 2'd1, 35'h7_0000_0001));
        tests++;
        if (if4.cmd_valid !== 4'b0010) begin fails++; $display("FAIL pre_reset_offer: got %b expected 0010", if4.cmd_valid); end
        #2;
        reset = 1'b1;
        vs_udr = 1'b1;
        #1;
        tests++;
        if (if4.cmd_valid !== 4'b0000 || busy !== 1'b0 || if4.jdo !== '0) begin fails++; $display("FAIL async_withdraw: valid=%b busy=%b expected 0000 0", if4.cmd_valid, busy); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || if4.cmd_valid !== 4'b0000 || err_ovf !== 1'b0) begin fails++; $display("FAIL held_strobe: busy=%b valid=%b ovf=%b expected 0 0000 0", busy, if4.cmd_valid, err_ovf); end
        vs_udr = 1'b0;
        repeat (3) @(negedge clk);
        s = mk_sr(1'b0, 2'd1, 35'h2_4680_1357);
        sr = s;
        ir_in = 2'd2;
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        @(negedge clk);
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (if4.cmd_ir !== 2'd2 || ir_q !== 2'd2) begin fails++; $display("FAIL same_cycle_ir: cmd_ir=%0d ir_q=%0d expected 2 2", if4.cmd_ir, ir_q); end
        tests++;
        if (if4.cmd_valid !== 4'b0010 || if4.jdo !== s || if4.cmd_action !== 1'b0) begin fails++; $display("FAIL same_cycle_cmd: valid=%b jdo=%h expected 0010 %h", if4.cmd_valid, if4.jdo, s); end
        if4.ch_ready = 4'b1111;
        @(negedge clk);
    endtask

    task automatic test_stats();
        do_reset();
        if4.ch_ready = 4'b1111;
        for (int k = 0; k < 3; k++) udr(mk_sr(1'b1, 2'd0, 35'(k)));
        udr(mk_sr(1'b0, 2'd3, 35'h3));
        repeat (2) @(negedge clk);
`ifdef DBG_DISPATCH_STATS_EN
        tests++;
        if (stat_cnt !== {16'd1, 16'd0, 16'd0, 16'd3}) begin fails++; $display("FAIL stats_counts: got %h expected %h", stat_cnt, {16'd1, 16'd0, 16'd0, 16'd3}); end
`else
        tests++;
        if (stat_cnt !== 64'd0) begin fails++; $display("FAIL stats_disabled: got %h expected 0", stat_cnt); end
`endif
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL stats_drained: got %b expected 0", busy); end
    endtask

    initial begin
        if4.ch_ready = 4'b0000;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_stall();
        test_overflow();
        test_badch();
        test_reset_hold();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
